traffic_start_req: RTL and testbench
====================================

// Module: traffic_start_req
// PURPOSE
//   Upstream front-end for the traffic light controller: turns a raw, asynchronous
//   push-button into the controller's start request. Synchronises and debounces
//   the button, then issues a fixed-width start pulse (o_srt -> controller in_srt).
//   Enforces a cooldown between starts and holds one press pending during pulse/cooldown.
// PARAMETERS
//   DEB_CYCLES   4    consecutive stable synchronised samples needed to change debounced level (>=1)
//   SRT_CYCLES   2    width of o_srt pulse in clock cycles (>=1)
//   COOL_CYCLES  40   cycles after pulse end before next pulse may start (>=1)
// PORTS
//   in_clk       input   1  clock, all logic on rising edge
//   in_rst       input   1  reset, synchronous, active-high
//   in_btn       input   1  raw push-button level, asynchronous, active-high
//   o_srt        output  1  start request to traffic controller, registered
//   o_pending    output  1  a press is latched, waiting for cooldown to end
//   o_cooldown   output  1  high while in COOL state
//   o_press_cnt  output  8  accepted debounced presses, saturates at 255
// BEHAVIOUR
//   - Reset (sync): sync flops, deb_lvl, deb_cnt, pending, counters, all outputs -> 0; state IDLE.
//     Reset mid-pulse: o_srt low after the reset edge; no pulse resumes.
//   - Sync: 2-flop synchroniser in_btn -> btn_s (both reset to 0).
//   - Debounce: btn_s==deb_lvl -> deb_cnt<=0. Else if deb_cnt==DEB_CYCLES-1 -> deb_lvl<=btn_s,
//     deb_cnt<=0; else deb_cnt++. A glitch shorter than DEB_CYCLES synchronised cycles is ignored.
//   - rise = deb_lvl & ~deb_lvl_d (deb_lvl_d = deb_lvl delayed 1 cycle). Each rise = 1 press;
//     o_press_cnt++ (saturating). Falling debounced edges do nothing.
//   - Latency: edge 0 = first edge sampling in_btn=1. btn_s=1 after edge 1, deb_lvl=1 after
//     edge 1+DEB_CYCLES, o_srt=1 after edge 2+DEB_CYCLES when in IDLE (default: edge 6).
//   - FSM (o_srt = state==FIRE, o_cooldown = state==COOL):
//     IDLE: rise -> FIRE, tmr<=0. Pending never set in IDLE.
//     FIRE: lasts exactly SRT_CYCLES cycles, then COOL, tmr<=0. rise here -> pending<=1.
//     COOL: lasts exactly COOL_CYCLES cycles. rise here -> pending<=1. On exit:
//       pending | rise -> FIRE, clear pending; else -> IDLE.
//   - Pending is 1-deep: extra presses in FIRE/COOL with pending=1 are dropped, still counted.
//   - Pending clears on the edge that enters FIRE; it sets and clears on separate edges only.
//   - Successive o_srt pulses are >= COOL_CYCLES low cycles apart; pulse width always SRT_CYCLES.
//   - Button held through reset release: deb_lvl restarts at 0, so exactly one press is taken
//     2+DEB_CYCLES edges after the first sampling edge post-reset.
//   - Timer widths: $clog2 of the largest count + 1; no wrap occurs within any state.
// TESTING
//   1 Reset: in_rst=1 for 3 cycles, in_btn=1 -> all outputs 0 throughout; after release
//     o_srt rises at edge 6 (defaults), exactly one press.
//   2 Clean press: in_btn 0->1 held 10 cycles -> o_srt high exactly 2 cycles starting edge 6,
//     o_cooldown high next 40 cycles, o_press_cnt=1.
//   3 Glitch: in_btn high 3 cycles then low (DEB_CYCLES=4) -> no o_srt, o_press_cnt stays 0.
//   4 Press during cooldown: 2nd press mid-COOL -> o_pending=1, 2nd pulse starts on the edge
//     COOL ends (exactly 40 low cycles after 1st pulse), o_pending=0 then, o_press_cnt=2.
//   5 Three presses in one cooldown -> one extra pulse only, o_press_cnt=3, pending cleared.
//   6 Reset asserted during FIRE (cycle 1 of 2) -> o_srt=0 next edge, state IDLE, counters 0.

Source files
------------

// File: rtl/traffic_start_req.sv
// Push-button front-end for the traffic light controller: synchronises and debounces
// the button, then issues fixed-width start pulses with an enforced cooldown between them.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for a debounced press
//   FIRE  | o_srt asserted for SRT_CYCLES cycles
//   COOL  | COOL_CYCLES cycles of lockout; one press may be held pending
module traffic_start_req #(
    parameter int DEB_CYCLES  = 4,
    parameter int SRT_CYCLES  = 2,
    parameter int COOL_CYCLES = 40
) (
    input  logic       in_clk,
    input  logic       in_rst,
    input  logic       in_btn,
    output logic       o_srt,
    output logic       o_pending,
    output logic       o_cooldown,
    output logic [7:0] o_press_cnt
);

    localparam int DW      = $clog2(DEB_CYCLES + 1);
    localparam int TMR_MAX = (SRT_CYCLES > COOL_CYCLES) ? SRT_CYCLES : COOL_CYCLES;
    localparam int TW      = $clog2(TMR_MAX + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] SRT_LAST  = TW'(SRT_CYCLES - 1);
    localparam logic [TW-1:0] COOL_LAST = TW'(COOL_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        COOL = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          pend_d;

    logic          btn_m, btn_s;
    logic          deb_lvl, deb_lvl_d;
    logic [DW-1:0] deb_cnt;
    logic          rise;

    assign rise = deb_lvl & ~deb_lvl_d;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            btn_m       <= 1'b0;
            btn_s       <= 1'b0;
            deb_lvl     <= 1'b0;
            deb_lvl_d   <= 1'b0;
            deb_cnt     <= '0;
            o_press_cnt <= '0;
        end else begin
            btn_m     <= in_btn;
            btn_s     <= btn_m;
            deb_lvl_d <= deb_lvl;
            // any sample agreeing with the current level restarts the stability count
            if (btn_s == deb_lvl) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_lvl <= btn_s;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
            if (rise && (o_press_cnt != 8'hFF)) begin
                o_press_cnt <= o_press_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q    <= IDLE;
            tmr_q      <= '0;
            o_pending  <= 1'b0;
            o_srt      <= 1'b0;
            o_cooldown <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            o_pending  <= pend_d;
            o_srt      <= (state_d == FIRE);
            o_cooldown <= (state_d == COOL);
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q + 1'b1;
        pend_d  = o_pending;
        case (state_q)
            IDLE: begin
                tmr_d = '0;
                if (rise) begin
                    state_d = FIRE;
                end
            end
            FIRE: begin
                if (rise) begin
                    pend_d = 1'b1;
                end
                if (tmr_q == SRT_LAST) begin
                    state_d = COOL;
                    tmr_d   = '0;
                end
            end
            COOL: begin
                if (rise) begin
                    pend_d = 1'b1;
                end
                if (tmr_q == COOL_LAST) begin
                    tmr_d = '0;
                    // a press arriving on the exit edge is served directly, never latched
                    if (o_pending || rise) begin
                        state_d = FIRE;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tmr_d   = '0;
                pend_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_start_req.sv
// Bench for traffic_start_req: directed reset cases, then scoreboarded presses checked
// against a pulse-schedule model derived from press times.
`timescale 1ns/1ps
module tb_traffic_start_req;

    localparam int DEB  = 4;
    localparam int SRT  = 2;
    localparam int COOL = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic       o_srt, o_pending, o_cooldown;
    logic [7:0] o_press_cnt;

    traffic_start_req #(
        .DEB_CYCLES (DEB),
        .SRT_CYCLES (SRT),
        .COOL_CYCLES(COOL)
    ) dut (
        .in_clk     (clk),
        .in_rst     (rst),
        .in_btn     (btn),
        .o_srt      (o_srt),
        .o_pending  (o_pending),
        .o_cooldown (o_cooldown),
        .o_press_cnt(o_press_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Pulse-schedule model: a pulse starting at edge s blocks until s+SRT+COOL; any
    // presses taking effect in (s, s+SRT+COOL] collapse into one pulse at that edge.
    int exp_q[$];
    int last_start;
    bit next_sched;
    int model_presses;

    task automatic model_reset();
        exp_q.delete();
        last_start    = -100000;
        next_sched    = 1'b0;
        model_presses = 0;
    endtask

    task automatic model_rise(int e);
        bit done;
        int x;
        done = 1'b0;
        model_presses++;
        for (int it = 0; it < 3 && !done; it++) begin
            x = last_start + SRT + COOL;
            if (next_sched) begin
                if (e <= x) done = 1'b1;
                else begin
                    last_start = x;
                    next_sched = 1'b0;
                end
            end else if (e <= x) begin
                exp_q.push_back(x);
                next_sched = 1'b1;
                done = 1'b1;
            end else begin
                exp_q.push_back(e);
                last_start = e;
                done = 1'b1;
            end
        end
    endtask

    // h cycles high then l cycles low (l >= DEB keeps every press independent)
    task automatic press(int h, int l);
        int t0;
        @(posedge clk);
        #1;
        btn = 1'b1;
        t0  = cyc + 1;
        if (h >= DEB) model_rise(t0 + 2 + DEB);
        repeat (h) @(posedge clk);
        #1;
        btn = 1'b0;
        repeat (l - 1) @(posedge clk);
    endtask

    bit   mon_en = 1'b0;
    int   hi_len = 0;
    int   cool_len = 0;
    logic prev_srt = 1'b0;
    logic prev_cool = 1'b0;

    always @(negedge clk) begin
        int e;
        if (mon_en) begin
            if (o_srt && !prev_srt) begin
                check("pulse_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("pulse_start", cyc, e);
                end
                check("pending_at_fire", int'(o_pending), 0);
            end
            if (!o_srt && prev_srt) check("pulse_width", hi_len, SRT);
            if (!o_cooldown && prev_cool) check("cool_len", cool_len, COOL);
            hi_len   = o_srt ? hi_len + 1 : 0;
            cool_len = o_cooldown ? cool_len + 1 : 0;
        end else begin
            hi_len   = 0;
            cool_len = 0;
        end
        prev_srt  = o_srt;
        prev_cool = o_cooldown;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        model_reset();

        // reset held with button pressed
        btn = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_srt", int'(o_srt), 0);
            check("rst_cool", int'(o_cooldown), 0);
            check("rst_pend", int'(o_pending), 0);
            check("rst_cnt", int'(o_press_cnt), 0);
        end
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("rel_srt_early", int'(o_srt), 0);
        @(posedge clk);
        #1;
        check("rel_srt_fire", int'(o_srt), 1);
        btn = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        check("rel_one_press", int'(o_press_cnt), 1);

        // reset during first FIRE cycle
        btn = 1'b1;
        hi  = 0;
        for (int i = 0; i < 20 && !o_srt; i++) begin
            @(posedge clk);
            #1;
        end
        check("fire_seen", int'(o_srt), 1);
        rst = 1'b1;
        btn = 1'b0;
        @(posedge clk);
        #1;
        check("midfire_srt", int'(o_srt), 0);
        check("midfire_cool", int'(o_cooldown), 0);
        check("midfire_cnt", int'(o_press_cnt), 0);
        rst = 1'b0;
        repeat (60) begin
            @(posedge clk);
            #1;
            hi += int'(o_srt);
        end
        check("no_resume", hi, 0);

        // scoreboarded phase
        model_reset();
        mon_en = 1'b1;

        press(3, 10);
        press(1, 10);
        repeat (20) @(posedge clk);
        #1;
        check("glitch_cnt", int'(o_press_cnt), 0);

        press(10, 60);
        #1;
        check("clean_cnt", int'(o_press_cnt), model_presses);

        press(6, 14);
        press(6, 10);
        #1;
        check("cool_pending", int'(o_pending), 1);
        repeat (50) @(posedge clk);
        #1;
        check("cool_pending_clr", int'(o_pending), 0);
        check("cool_cnt", int'(o_press_cnt), model_presses);

        press(6, 10);
        press(6, 10);
        press(6, 10);
        repeat (100) @(posedge clk);
        #1;
        check("three_pending_clr", int'(o_pending), 0);
        check("three_cnt", int'(o_press_cnt), model_presses);

        repeat (150) press(int'($urandom_range(1, 8)), int'($urandom_range(DEB, 60)));
        repeat (100) @(posedge clk);
        #1;
        check("rand_cnt", int'(o_press_cnt), model_presses);

        repeat (260) press(DEB, DEB);

        for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (60) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        check("press_cnt_sat", int'(o_press_cnt), (model_presses > 255) ? 255 : model_presses);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
